antirebote_multi: RTL and testbench
===================================

// Module: antirebote_multi
//
// PURPOSE
// - N-channel debouncer for mechanical pushbuttons/switches, successor to the single-channel debouncer.
// - Per channel: 2-FF synchroniser, stability counter, clean level, 1-cycle press/release pulses.
// - Sits between raw board pins and the control FSMs; all outputs are synchronous to clk.
//
// PARAMETERS
// - N_CH          4        number of independent channels (>=1)
// - STABLE_COUNT  200_000  consecutive disagreeing cycles before level updates (~10 ms @ 20 MHz, >=2)
// - LONG_COUNT    20_000_000  cycles btn_out must stay high for long-press pulse (~1 s @ 20 MHz, >=2)
//
// PORTS
// - clk          in   1     system clock
// - rst          in   1     synchronous reset, active high
// - btn_in       in   N_CH  raw asynchronous button inputs
// - btn_out      out  N_CH  debounced level
// - btn_press    out  N_CH  1-cycle pulse on debounced rising edge
// - btn_release  out  N_CH  1-cycle pulse on debounced falling edge
// - btn_long     out  N_CH  1-cycle long-press pulse (see CONFIGURATION)
//
// BEHAVIOUR
// - One clock, reset synchronous and active-high; sampled on posedge clk only.
// - Reset: sync FFs, counters, btn_out, btn_press, btn_release, btn_long all 0; reset mid-bounce discards progress.
// - Sync: sync0[i] <= btn_in[i]; sync1[i] <= sync0[i]; only sync1 feeds the counter logic.
// - Counter width $clog2(STABLE_COUNT); one counter per channel, channels fully independent.
// - If sync1[i] == btn_out[i]: cnt[i] <= 0 (any bounce back restarts the window).
// - Else if cnt[i] == STABLE_COUNT-1: btn_out[i] <= sync1[i]; cnt[i] <= 0.
// - Else cnt[i] <= cnt[i] + 1.
// - Latency: btn_in change held steady -> btn_out changes STABLE_COUNT+2 clocks after first sampling edge.
// - Glitch shorter than STABLE_COUNT cycles at sync1 never reaches btn_out.
// - btn_press[i]/btn_release[i] registered: high exactly the cycle after btn_out[i] rises/falls, else 0.
// - press and release never high together on one channel; different channels may pulse in the same cycle.
// - Counter never wraps: it is cleared on update or agreement before reaching STABLE_COUNT.
//
// CONFIGURATION
// - Macro ANTIREBOTE_LONG_PRESS_EN.
// - Defined: per-channel hold counter ($clog2(LONG_COUNT) bits), cleared while btn_out[i]==0 and on rst.
//   - Increments each cycle btn_out[i]==1; at LONG_COUNT-1 it asserts btn_long[i] for 1 cycle and saturates.
//   - Exactly one btn_long pulse per press; rearms only after btn_out[i] returns to 0.
//   - Release before LONG_COUNT: no btn_long; btn_release still pulses normally.
// - Not defined: hold counters not instantiated; btn_long tied to 0; LONG_COUNT ignored.
//
// TESTING (bench uses N_CH=2, STABLE_COUNT=4, LONG_COUNT=10)
// - rst high 3 cycles with btn_in=2'b11 -> all outputs 0 during and the cycle after reset.
// - ch0 steps 0->1 and holds -> btn_out[0]=1 exactly 6 clocks later; btn_press[0]=1 for one cycle next; ch1 unaffected.
// - ch0 bounces 1,0,1,0,1 (1-cycle each) then holds 1 -> btn_out[0] stays 0 until 4 stable sync1 cycles, single btn_press.
// - ch0 and ch1 released same cycle -> both btn_release bits pulse in same cycle, one cycle each.
// - rst asserted after 3 disagreeing cycles -> btn_out stays 0; after rst, full 6-clock latency needed again.
// - LONG_PRESS_EN: hold ch1 for 20 cycles -> one btn_long[1] pulse 10 cycles after btn_out[1] rises; hold 5 cycles -> none.

Source files
------------

// File: rtl/antirebote_multi.sv
// ---------------------------------------------------------------------------
// antirebote_multi
//
// N-channel debouncer for mechanical pushbuttons and switches. Each channel
// runs through a 2-FF synchroniser, then a stability counter that only lets
// the clean level follow the synchronised input once it has disagreed with
// the current clean level for STABLE_COUNT consecutive cycles. Registered
// 1-cycle pulses mark debounced rising (press) and falling (release) edges.
//
// Optional feature, enabled by defining ANTIREBOTE_LONG_PRESS_EN:
//   a per-channel hold counter raises btn_long for one cycle once btn_out
//   has stayed high for LONG_COUNT cycles. When the macro is not defined,
//   btn_long is tied to 0 and LONG_COUNT has no effect.
//
// Parameters
//   N_CH          number of independent channels (>= 1)
//   STABLE_COUNT  consecutive disagreeing cycles before btn_out updates (>= 2)
//   LONG_COUNT    cycles btn_out must stay high for a long-press pulse (>= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   btn_in       raw asynchronous button inputs            [N_CH]
//   btn_out      debounced level                           [N_CH]
//   btn_press    1-cycle pulse after btn_out rises          [N_CH]
//   btn_release  1-cycle pulse after btn_out falls          [N_CH]
//   btn_long     1-cycle long-press pulse                  [N_CH]
// ---------------------------------------------------------------------------
module antirebote_multi #(
    parameter int N_CH         = 4,
    parameter int STABLE_COUNT = 200_000,
    parameter int LONG_COUNT   = 20_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long
);

    localparam int              CW       = $clog2(STABLE_COUNT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_COUNT - 1);

    // Elaboration-time guard against configurations the logic cannot honour.
    if (N_CH < 1 || STABLE_COUNT < 2 || LONG_COUNT < 2) begin : g_bad_param
        $error("antirebote_multi: N_CH must be >= 1, STABLE_COUNT and LONG_COUNT >= 2");
    end

    logic [N_CH-1:0]         sync0;
    logic [N_CH-1:0]         sync1;
    logic [N_CH-1:0]         btn_out_q;   // btn_out one cycle late, for edge pulses
    logic [N_CH-1:0][CW-1:0] cnt;

    // Synchroniser, stability counters and edge pulses. Any cycle where the
    // synchronised input agrees with the clean level restarts the window, so
    // a bounce shorter than STABLE_COUNT cycles never reaches btn_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0       <= '0;
            sync1       <= '0;
            btn_out     <= '0;
            btn_out_q   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            cnt         <= '0;
        end else begin
            sync0       <= btn_in;
            sync1       <= sync0;
            btn_out_q   <= btn_out;
            // btn_out only changes on a counter terminal count, so these
            // pulses land exactly the cycle after the clean level moves.
            btn_press   <= btn_out & ~btn_out_q;
            btn_release <= ~btn_out & btn_out_q;
            for (int i = 0; i < N_CH; i++) begin
                if (sync1[i] == btn_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_out[i] <= sync1[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef ANTIREBOTE_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_COUNT);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_COUNT - 1);

    logic [N_CH-1:0][LW-1:0] hold_cnt;
    // Set once the long pulse for the current press has fired; keeps the
    // saturated counter from re-firing until the button is released.
    logic [N_CH-1:0]         long_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            long_done <= '0;
            btn_long  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                btn_long[i] <= 1'b0;
                if (!btn_out[i]) begin
                    hold_cnt[i]  <= '0;
                    long_done[i] <= 1'b0;
                end else if (hold_cnt[i] == HOLD_LAST) begin
                    if (!long_done[i]) begin
                        btn_long[i]  <= 1'b1;
                        long_done[i] <= 1'b1;
                    end
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + LW'(1);
                end
            end
        end
    end
`else
    assign btn_long = '0;
`endif

endmodule

// File: tb/tb_antirebote_multi.sv
// ---------------------------------------------------------------------------
// tb_antirebote_multi
//
// Directed bench for antirebote_multi with N_CH=2, STABLE_COUNT=4,
// LONG_COUNT=10. Inputs are driven 1 time unit after a rising edge and
// outputs are sampled at the same point, so "tick(n)" means n clock edges.
// With STABLE_COUNT=4, a held input step is seen on btn_out after 6 edges,
// the press/release pulse after 7, and it is gone after 8.
// ---------------------------------------------------------------------------
module tb_antirebote_multi;

    localparam int N_CH         = 2;
    localparam int STABLE_COUNT = 4;
    localparam int LONG_COUNT   = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_out;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_long;

    int total = 0;
    int bad   = 0;

    antirebote_multi #(
        .N_CH        (N_CH),
        .STABLE_COUNT(STABLE_COUNT),
        .LONG_COUNT  (LONG_COUNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_out    (btn_out),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            total++;
            if ({btn_out, btn_press, btn_release, btn_long} !== 8'h00) begin
                bad++;
                $display("FAIL reset_during cycle %0d: out=%b press=%b rel=%b long=%b required all 0",
                         k, btn_out, btn_press, btn_release, btn_long);
            end
        end
        rst = 1'b0;
        tick(1);
        total++;
        if ({btn_out, btn_press, btn_release, btn_long} !== 8'h00) begin
            bad++;
            $display("FAIL reset_after: out=%b press=%b rel=%b long=%b required all 0",
                     btn_out, btn_press, btn_release, btn_long);
        end
        btn_in = 2'b00;
        tick(6);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL reset_settle: out=%b required 00", btn_out);
        end
    endtask

    task automatic test_step();
        btn_in = 2'b01;
        tick(5);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL step_early: out=%b required 00", btn_out);
        end
        tick(1);
        total++;
        if (btn_out !== 2'b01 || btn_press !== 2'b00) begin
            bad++;
            $display("FAIL step_rise: out=%b press=%b required out=01 press=00", btn_out, btn_press);
        end
        tick(1);
        total++;
        if (btn_press !== 2'b01 || btn_release !== 2'b00) begin
            bad++;
            $display("FAIL step_press: press=%b rel=%b required press=01 rel=00", btn_press, btn_release);
        end
        tick(1);
        total++;
        if (btn_press !== 2'b00 || btn_out !== 2'b01) begin
            bad++;
            $display("FAIL step_press_end: press=%b out=%b required press=00 out=01", btn_press, btn_out);
        end
        // release ch0 and check the single release pulse
        btn_in = 2'b00;
        tick(6);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL step_fall: out=%b required 00", btn_out);
        end
        tick(1);
        total++;
        if (btn_release !== 2'b01 || btn_press !== 2'b00) begin
            bad++;
            $display("FAIL step_release: rel=%b press=%b required rel=01 press=00", btn_release, btn_press);
        end
        tick(1);
        total++;
        if (btn_release !== 2'b00) begin
            bad++;
            $display("FAIL step_release_end: rel=%b required 00", btn_release);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int         presses;
        pat     = 5'b10101;
        presses = 0;
        for (int j = 0; j < 5; j++) begin
            btn_in = {1'b0, pat[j]};
            tick(1);
            presses += int'(btn_press[0]);
            total++;
            if (btn_out !== 2'b00) begin
                bad++;
                $display("FAIL bounce_glitch step %0d: out=%b required 00", j, btn_out);
            end
        end
        // last pattern value (1) is now held; 1 edge already elapsed
        for (int k = 2; k <= 8; k++) begin
            tick(1);
            presses += int'(btn_press[0]);
            if (k == 5) begin
                total++;
                if (btn_out !== 2'b00) begin
                    bad++;
                    $display("FAIL bounce_early: out=%b required 00", btn_out);
                end
            end
            if (k == 6) begin
                total++;
                if (btn_out !== 2'b01) begin
                    bad++;
                    $display("FAIL bounce_rise: out=%b required 01", btn_out);
                end
            end
        end
        total++;
        if (presses !== 1) begin
            bad++;
            $display("FAIL bounce_press_count: got %0d required 1", presses);
        end
    endtask

    task automatic test_simul_release();
        // ch0 is already high; bring ch1 up as well
        btn_in = 2'b11;
        tick(8);
        total++;
        if (btn_out !== 2'b11) begin
            bad++;
            $display("FAIL simul_both_high: out=%b required 11", btn_out);
        end
        btn_in = 2'b00;
        tick(6);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL simul_fall: out=%b required 00", btn_out);
        end
        tick(1);
        total++;
        if (btn_release !== 2'b11 || btn_press !== 2'b00) begin
            bad++;
            $display("FAIL simul_release: rel=%b press=%b required rel=11 press=00", btn_release, btn_press);
        end
        tick(1);
        total++;
        if (btn_release !== 2'b00) begin
            bad++;
            $display("FAIL simul_release_end: rel=%b required 00", btn_release);
        end
    endtask

    task automatic test_reset_mid();
        btn_in = 2'b01;
        tick(5);   // sync1 disagrees for 3 counted cycles; next edge would update
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL midrst_before: out=%b required 00", btn_out);
        end
        rst = 1'b1;
        tick(1);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL midrst_in_reset: out=%b required 00", btn_out);
        end
        rst = 1'b0;
        tick(5);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL midrst_progress_kept: out=%b required 00", btn_out);
        end
        tick(1);
        total++;
        if (btn_out !== 2'b01) begin
            bad++;
            $display("FAIL midrst_full_latency: out=%b required 01", btn_out);
        end
        btn_in = 2'b00;
        tick(8);
        total++;
        if (btn_out !== 2'b00) begin
            bad++;
            $display("FAIL midrst_cleanup: out=%b required 00", btn_out);
        end
    endtask

    task automatic test_long_press();
        logic [N_CH-1:0] exp_long;
        int              rel_seen;
        btn_in = 2'b10;
        tick(6);
        total++;
        if (btn_out !== 2'b10) begin
            bad++;
            $display("FAIL long_rise: out=%b required 10", btn_out);
        end
        for (int k = 1; k <= 20; k++) begin
            tick(1);
`ifdef ANTIREBOTE_LONG_PRESS_EN
            exp_long = (k == LONG_COUNT) ? 2'b10 : 2'b00;
`else
            exp_long = 2'b00;
`endif
            total++;
            if (btn_long !== exp_long) begin
                bad++;
                $display("FAIL long_hold k=%0d: long=%b required %b", k, btn_long, exp_long);
            end
        end
        btn_in = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            total++;
            if (btn_long !== 2'b00) begin
                bad++;
                $display("FAIL long_after_release k=%0d: long=%b required 00", k, btn_long);
            end
        end
        // short press: btn_out high for 6 cycles, well under LONG_COUNT
        btn_in   = 2'b10;
        rel_seen = 0;
        tick(6);
        total++;
        if (btn_out !== 2'b10) begin
            bad++;
            $display("FAIL short_rise: out=%b required 10", btn_out);
        end
        btn_in = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            rel_seen += int'(btn_release[1]);
            total++;
            if (btn_long !== 2'b00) begin
                bad++;
                $display("FAIL short_no_long k=%0d: long=%b required 00", k, btn_long);
            end
        end
        total++;
        if (rel_seen !== 1) begin
            bad++;
            $display("FAIL short_release_count: got %0d required 1", rel_seen);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence / report ----------------
    initial begin
        rst    = 1'b1;
        btn_in = 2'b11;
        test_reset();
        test_step();
        test_bounce();
        test_simul_release();
        test_reset_mid();
        test_long_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
